alu_seq: RTL and testbench

//  Parametrised, registered successor to the combinational EXE-stage ALU.

---
 rtl/alu_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered EXE-stage ALU with valid/ready handshakes, bit-serial shifts and Z/N/C flags.
// Optional feature: define ALU_MUL_EN to add a WIDTH-cycle shift-add multiplier on mode 9.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef ALU_MUL_EN
  localparam logic [1:0] ST_MUL   = 2'd2;
  localparam logic [3:0] OP_MUL   = 4'd9;
`endif

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_OUT  = 4'd6;
  localparam logic [3:0] OP_IN   = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             left_q, left_d;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  logic             ld_res;
  logic [WIDTH-1:0] res_new;
  logic             c_new;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d, prod_add;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  assign prod_add = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
`endif

  // Reset also blocks acceptance so the ID/EXE stall logic sees no ready while reset is held.
  assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = s2[SHW-1:0];
  assign add_w    = {1'b0, s1} + {1'b0, s2};
  assign sub_w    = {1'b0, s1} - {1'b0, s2};
  assign sh_out   = left_q ? acc_q[WIDTH-1] : acc_q[0];
  assign sh_next  = left_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};

  // Next-state, result and flag computation
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    ld_res      = 1'b0;
    res_new     = '0;
    c_new       = 1'b0;
`ifdef ALU_MUL_EN
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          case (mode)
            OP_ADD:  begin ld_res = 1'b1; res_new = add_w[WIDTH-1:0]; c_new = add_w[WIDTH]; end
            OP_SUB:  begin ld_res = 1'b1; res_new = sub_w[WIDTH-1:0]; c_new = sub_w[WIDTH]; end
            OP_NAND: begin ld_res = 1'b1; res_new = ~(s1 & s2); end
            OP_OUT, OP_IN: begin ld_res = 1'b1; res_new = s1; end
            OP_MOV:  begin ld_res = 1'b1; res_new = s2; end
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                ld_res  = 1'b1;
                res_new = s1;
              end else begin
                out_valid_d = 1'b0;
                state_d     = ST_SHIFT;
                busy_d      = 1'b1;
                acc_d       = s1;
                cnt_d       = CW'(shamt);
                left_d      = (mode == OP_SHL);
              end
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
              out_valid_d = 1'b0;
              state_d     = ST_MUL;
              busy_d      = 1'b1;
              prod_d      = '0;
              mcand_d     = {{WIDTH{1'b0}}, s1};
              mplier_d    = s2;
              cnt_d       = CW'(WIDTH);
            end
`endif
            default: ;
          endcase
        end
      end

      ST_SHIFT: begin
        acc_d = sh_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          ld_res      = 1'b1;
          res_new     = sh_next;
          c_new       = sh_out;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end

`ifdef ALU_MUL_EN
      ST_MUL: begin
        prod_d   = prod_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          ld_res      = 1'b1;
          res_new     = prod_add[WIDTH-1:0];
          c_new       = |prod_add[2*WIDTH-1:WIDTH];
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (ld_res) begin
      result_d = res_new;
      z_d      = (res_new == '0);
      n_d      = res_new[WIDTH-1];
      c_d      = c_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
`ifdef ALU_MUL_EN
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
`ifdef ALU_MUL_EN
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
`endif
    end
  end

  assign result    = result_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, directed multi-cycle sequences and
// a random phase, all results checked through an expected-result queue.
module tb_alu_seq;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       n;
    logic       c;
  } res_t;

  typedef struct {
    logic [3:0] m;
    logic [7:0] a;
    logic [7:0] b;
    res_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic       flag_z, flag_n, flag_c, busy;
  logic [3:0] mode;
  logic [7:0] s1, s2, result;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  res_t mdl_last;
  vec_t tbl[16];

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .s1(s1), .s2(s2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic res_t model(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                                 input res_t prev);
    res_t o;
    int   s;
    int   sh;
    o  = prev;
    sh = int'(b[2:0]);
    case (m)
      4'd1: begin s = int'(a) + int'(b); o.r = 8'(s); o.c = (s > 255); end
      4'd2: begin o.r = a - b; o.c = (a < b); end
      4'd3: begin o.r = ~(a & b); o.c = 1'b0; end
      4'd4: if (sh == 0) begin o.r = a; o.c = 1'b0; end
            else begin o.r = a << sh; o.c = a[8 - sh]; end
      4'd5: if (sh == 0) begin o.r = a; o.c = 1'b0; end
            else begin o.r = a >> sh; o.c = a[sh - 1]; end
      4'd6, 4'd7: begin o.r = a; o.c = 1'b0; end
      4'd8: begin o.r = b; o.c = 1'b0; end
`ifdef ALU_MUL_EN
      4'd9: begin s = int'(a) * int'(b); o.r = 8'(s); o.c = (s > 255); end
`endif
      default: return prev;
    endcase
    o.z = (o.r == 8'h00);
    o.n = o.r[7];
    return o;
  endfunction

  function automatic vec_t mk(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] r, input logic z, input logic n, input logic c);
    vec_t v;
    v.m = m; v.a = a; v.b = b;
    v.e = {r, z, n, c};
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                       input res_t e, input bit bp);
    bit got;
    got = 1'b0;
    exp_q.push_back(e);
    if (bp) out_ready = ($urandom_range(0, 3) != 0);
    mode = m; s1 = a; s2 = b; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    if (!got) check("issue_timeout", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: every retired result must match the oldest expectation.
  always @(negedge clk) begin
    res_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'({result, flag_z, flag_n, flag_c}), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out", 32'({result, flag_z, flag_n, flag_c}), 32'(e));
      end
    end
  end

  initial begin
    tbl[0]  = mk(4'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    tbl[1]  = mk(4'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    tbl[2]  = mk(4'd2, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b1);
    tbl[3]  = mk(4'd3, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(4'd0, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(4'd8, 8'h11, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(4'd6, 8'h9C, 8'h00, 8'h9C, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(4'd7, 8'h00, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(4'd2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(4'd4, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(4'd5, 8'h81, 8'h01, 8'h40, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(4'd4, 8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(4'd5, 8'hF0, 8'h0C, 8'h0F, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(4'hF, 8'h11, 8'h22, 8'h0F, 1'b0, 1'b0, 1'b0);
`ifdef ALU_MUL_EN
    tbl[14] = mk(4'd9, 8'hAA, 8'h01, 8'hAA, 1'b0, 1'b1, 1'b0);
`else
    tbl[14] = mk(4'd9, 8'hAA, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);
`endif
    tbl[15] = mk(4'd2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset held with a pending op
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    mode = 4'd1; s1 = 8'h7F; s2 = 8'h01;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_result", 32'({result, flag_z, flag_n, flag_c}), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'(1));
    check("post_rst_valid", 32'(out_valid), 32'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) issue(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].e, 1'b0);
    mdl_last = tbl[15].e;

    // SHL by 3: busy for three cycles, operand changes ignored
    repeat (2) @(posedge clk); #1;
    exp_q.push_back(res_t'({8'h08, 1'b0, 1'b0, 1'b0}));
    mode = 4'd4; s1 = 8'h81; s2 = 8'h03; in_valid = 1'b1;
    @(negedge clk);
    check("shl_accept", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; mode = 4'd2; s1 = 8'h00; s2 = 8'h07;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("shl_busy", 32'({busy, in_ready, out_valid}), 32'(3'b100));
    end
    @(negedge clk);
    check("shl_done", 32'({busy, out_valid}), 32'(2'b01));
    mdl_last = res_t'({8'h08, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;

    // Backpressure on a MOV result, then back-to-back ADD acceptance
    exp_q.push_back(res_t'({8'h5A, 1'b0, 1'b0, 1'b0}));
    mode = 4'd8; s1 = 8'h33; s2 = 8'h5A; in_valid = 1'b1;
    @(negedge clk);
    check("mov_accept", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    out_ready = 1'b0; mode = 4'd1; s1 = 8'h10; s2 = 8'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_hold", 32'({result, out_valid, in_ready}), 32'({8'h5A, 1'b1, 1'b0}));
    end
    @(posedge clk); #1;
    exp_q.push_back(res_t'({8'h30, 1'b0, 1'b0, 1'b0}));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", 32'(out_valid), 32'(1));
    @(posedge clk); #1;

    // Reset during a 7-bit shift abandons it
    mode = 4'd5; s1 = 8'hFF; s2 = 8'h07; in_valid = 1'b1;
    @(negedge clk);
    check("shr7_accept", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_state", 32'({out_valid, busy, in_ready, result}), 32'({3'b001, 8'h00}));
    mdl_last = '0;
    repeat (10) @(posedge clk); #1;
    check("midrst_idle", 32'({out_valid, busy}), 32'(0));

`ifdef ALU_MUL_EN
    exp_q.push_back(res_t'({8'hFF, 1'b0, 1'b1, 1'b0}));
    mode = 4'd9; s1 = 8'h0F; s2 = 8'h11; in_valid = 1'b1;
    @(negedge clk);
    check("mul_accept", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("mul_busy", 32'({busy, out_valid}), 32'(2'b10));
    end
    @(negedge clk);
    check("mul_done", 32'({busy, out_valid}), 32'(2'b01));
    mdl_last = res_t'({8'hFF, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
`endif

    // Random operations with light backpressure
    for (int i = 0; i < 40; i++) begin
      logic [3:0] m;
      logic [7:0] a, b;
      res_t       e;
      m = 4'($urandom_range(0, 15));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      e = model(m, a, b, mdl_last);
      mdl_last = e;
      issue(m, a, b, e, 1'b1);
    end

    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
